// File: rtl/config_reg_pkg.sv
// -----------------------------------------------------------------------------
// config_reg_pkg
// Shared definitions for the configuration register block:
//   - default bus/address widths
//   - register address map as an enum (3-bit encoded, 0..7)
//   - per-register reset values and a lookup function by address
// -----------------------------------------------------------------------------
package config_reg_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;
    localparam int NUM_REGS   = 8;

    typedef enum logic [2:0] {
        ADC0_REG         = 3'd0,
        ADC1_REG         = 3'd1,
        TEMP_SENSOR0_REG = 3'd2,
        TEMP_SENSOR1_REG = 3'd3,
        ANALOG_TEST      = 3'd4,
        DIGITAL_TEST     = 3'd5,
        AMP_GAIN         = 3'd6,
        DIGITAL_CONFIG   = 3'd7
    } reg_addr_e;

    localparam logic [15:0] ADC0_RST         = 16'hFFFF;
    localparam logic [15:0] ADC1_RST         = 16'h0000;
    localparam logic [15:0] TEMP_SENSOR0_RST = 16'h0000;
    localparam logic [15:0] TEMP_SENSOR1_RST = 16'h0000;
    localparam logic [15:0] ANALOG_TEST_RST  = 16'hABCD;
    localparam logic [15:0] DIGITAL_TEST_RST = 16'h0000;
    localparam logic [15:0] AMP_GAIN_RST     = 16'h0000;
    localparam logic [15:0] DIGITAL_CFG_RST  = 16'h0001;

    // Reset value of the register living at a given address.
    function automatic logic [15:0] reset_value(input reg_addr_e a);
        logic [15:0] v;
        case (a)
            ADC0_REG:         v = ADC0_RST;
            ADC1_REG:         v = ADC1_RST;
            TEMP_SENSOR0_REG: v = TEMP_SENSOR0_RST;
            TEMP_SENSOR1_REG: v = TEMP_SENSOR1_RST;
            ANALOG_TEST:      v = ANALOG_TEST_RST;
            DIGITAL_TEST:     v = DIGITAL_TEST_RST;
            AMP_GAIN:         v = AMP_GAIN_RST;
            DIGITAL_CONFIG:   v = DIGITAL_CFG_RST;
            default:          v = 16'h0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/config_reg_if.sv
// -----------------------------------------------------------------------------
// config_reg_if
// Register access bus for config_reg.
//   write    : write enable for the addressed register
//   data_in  : write data (full word)
//   address  : register select, shared by read and write
//   data_out : combinational read data of the addressed register
// Modports: master drives the request side, slave (the register block)
// returns data_out.
// -----------------------------------------------------------------------------
interface config_reg_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              write;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_out;

    modport master (
        output write,
        output data_in,
        output address,
        input  data_out
    );

    modport slave (
        input  write,
        input  data_in,
        input  address,
        output data_out
    );
endinterface

// File: rtl/cfg_reg_word.sv
// -----------------------------------------------------------------------------
// cfg_reg_word
// One DATA_W-bit storage word with a synchronous active-high reset to
// RESET_VAL. Reset has priority over wr_en, so a write in a reset cycle
// is discarded.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   wr_en : load d on the next rising edge
//   d     : write data
//   q     : current register contents
// -----------------------------------------------------------------------------
module cfg_reg_word #(
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RESET_VAL;
        end else if (wr_en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/config_reg.sv
// -----------------------------------------------------------------------------
// config_reg
// Eight-entry configuration register file with full-word writes and a
// combinational read port.
// Ports:
//   clk   : clock, all state updates on its rising edge
//   reset : synchronous active-high reset, loads per-register reset values
//           and overrides any write in the same cycle
//   bus   : config_reg_if.slave (write, data_in, address -> data_out)
// Read data is register[address] with no bypass of data_in, so a
// read-during-write shows the old value until the edge.
// -----------------------------------------------------------------------------
module config_reg
    import config_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    config_reg_if.slave  bus
);

    logic [NUM_REGS-1:0] w_wr_en;
    logic [DATA_W-1:0]   w_q [NUM_REGS];
    logic [DATA_W-1:0]   w_rd_data;

    // Write decode. An address that matches no entry (including an unknown
    // value in simulation, where the equality test is not true) enables
    // nothing, so registers cannot be corrupted by a bad address.
    always_comb begin
        w_wr_en = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.write && (bus.address == ADDR_W'(i))) begin
                w_wr_en[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_word
        cfg_reg_word #(
            .DATA_W    (DATA_W),
            .RESET_VAL (DATA_W'(reset_value(reg_addr_e'(g))))
        ) u_word (
            .clk   (clk),
            .reset (reset),
            .wr_en (w_wr_en[g]),
            .d     (bus.data_in),
            .q     (w_q[g])
        );
    end

    // Read mux: purely combinational, zero-cycle latency from address.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.address == ADDR_W'(i)) begin
                w_rd_data = w_q[i];
            end
        end
    end

    assign bus.data_out = w_rd_data;

endmodule

// File: tb/tb_config_reg.sv
// -----------------------------------------------------------------------------
// tb_config_reg
// Self-checking bench for config_reg. The driver applies one operation per
// cycle, predicts data_out from a reference array of register values and
// queues the prediction; a separate monitor pops and compares on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_config_reg;

    localparam int DW = 16;
    localparam int AW = 3;

    localparam logic [15:0] RST_TAB [8] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
                                            16'hABCD, 16'h0000, 16'h0000, 16'h0001};

    logic clk = 1'b0;
    logic reset;

    config_reg_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    config_reg #(.DATA_W(DW), .ADDR_W(AW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference state: what each register holds after the most recent edge
    // (including the effect of the operation currently being driven, once
    // its prediction has been queued).
    logic [15:0] model [8];
    bit          model_ok = 1'b0;

    logic [15:0] exp_q  [$];
    string       name_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    // One bus cycle: drive inputs just after the rising edge, queue the value
    // data_out must show before the next edge (old contents), then apply the
    // operation to the model as the next edge will.
    task automatic cycle(input bit rst, input bit wr, input logic [2:0] a,
                         input logic [15:0] d, input string nm);
        @(posedge clk);
        #1;
        reset       = rst;
        bus.write   = wr;
        bus.address = a;
        bus.data_in = d;
        if (model_ok) begin
            exp_q.push_back(model[a]);
            name_q.push_back(nm);
        end
        if (rst) begin
            for (int i = 0; i < 8; i++) model[i] = RST_TAB[i];
            model_ok = 1'b1;
        end else if (wr && model_ok) begin
            model[a] = d;
        end
    endtask

    task automatic read_all(input string nm);
        for (int a = 0; a < 8; a++) cycle(1'b0, 1'b0, 3'(a), 16'(a * 16'h1111), nm);
    endtask

    task automatic write_all(input logic [15:0] d, input string nm);
        for (int a = 0; a < 8; a++) cycle(1'b0, 1'b1, 3'(a), d, nm);
    endtask

    // Monitor
    initial begin
        logic [15:0] e;
        string       nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_cmp++;
                if (bus.data_out !== e) begin
                    n_bad++;
                    $display("FAIL %s: addr=%0d data_out=%h expected=%h t=%0t",
                             nm, bus.address, bus.data_out, e, $time);
                end
            end
        end
    end

    // Driver
    initial begin
        reset       = 1'b1;
        bus.write   = 1'b1;
        bus.address = 3'd0;
        bus.data_in = 16'h7777;

        // Reset held over several edges with a pending write; then read map.
        cycle(1'b1, 1'b1, 3'd0, 16'h7777, "reset_hold");
        cycle(1'b1, 1'b1, 3'd4, 16'h7777, "reset_hold");
        cycle(1'b1, 1'b0, 3'd7, 16'h0000, "reset_hold");
        read_all("reset_vals");

        // 0110 to each address in turn, then read everything back.
        for (int a = 0; a < 8; a++) begin
            cycle(1'b0, 1'b1, 3'(a), 16'h0110, "wr_0110");
            read_all("rd_0110");
        end

        // All bits 0->1 then 1->0.
        write_all(16'hFFFF, "wr_ffff");
        read_all("rd_ffff");
        write_all(16'h0000, "wr_0000");
        read_all("rd_0000");

        // Walking ones, read back the written word and a neighbour.
        for (int n = 0; n < 16; n++) begin
            for (int a = 0; a < 8; a++) begin
                cycle(1'b0, 1'b1, 3'(a), 16'(1 << n), "walk_wr");
                cycle(1'b0, 1'b0, 3'(a), 16'h0000, "walk_rd");
                cycle(1'b0, 1'b0, 3'((a + 1) % 8), 16'h0000, "walk_alias");
            end
        end

        // Write disabled with data on the bus: nothing changes.
        for (int a = 0; a < 8; a++) cycle(1'b0, 1'b0, 3'(a), 16'h1234, "no_write");
        read_all("rd_no_write");

        // Same-address last-write-wins.
        cycle(1'b0, 1'b1, 3'd3, 16'h1111, "lww");
        cycle(1'b0, 1'b1, 3'd3, 16'h2222, "lww");
        cycle(1'b0, 1'b1, 3'd3, 16'h3333, "lww");
        cycle(1'b0, 1'b0, 3'd3, 16'h0000, "lww_rd");

        // Reset discards a same-cycle write.
        cycle(1'b0, 1'b1, 3'd6, 16'h5A5A, "amp_wr");
        cycle(1'b0, 1'b0, 3'd6, 16'h0000, "amp_rd");
        cycle(1'b1, 1'b1, 3'd6, 16'h7777, "rst_over_wr");
        cycle(1'b0, 1'b0, 3'd6, 16'h0000, "amp_after_rst");
        cycle(1'b0, 1'b0, 3'd4, 16'h0000, "analog_after_rst");

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            cycle(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 16'($urandom), "random");
        end
        read_all("rd_final");

        // Let the monitor drain the queue, bounded.
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        if (n_cmp < 12) begin
            n_bad++;
            $display("FAIL count: compared=%0d required>=12", n_cmp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/config_reg.md
CONFIG_REG -- requirements
Module: config_reg

Interface
REQ-001 The module SHALL expose parameter DATA_W, default 16: register and data bus width.
REQ-002 The module SHALL expose parameter ADDR_W, default 3: address width, giving 8 registers.
REQ-003 Port clk SHALL be input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be input, 1 bit: reset, synchronous and active-high.
REQ-005 Port write SHALL be input, 1 bit: write enable for the addressed register.
REQ-006 Port data_in SHALL be input, DATA_W bits: write data.
REQ-007 Port address SHALL be input, ADDR_W bits: register select for both read and write.
REQ-008 Port data_out SHALL be output, DATA_W bits: contents of the addressed register.

Function
REQ-009 The block SHALL hold eight DATA_W-bit registers with this address map:
- 0 adc0_reg
- 1 adc1_reg
- 2 temp_sensor0_reg
- 3 temp_sensor1_reg
- 4 analog_test
- 5 digital_test
- 6 amp_gain
- 7 digital_config
REQ-010 Reset values SHALL be:
- adc0_reg = 16'hFFFF
- adc1_reg = 16'h0000
- temp_sensor0_reg = 16'h0000
- temp_sensor1_reg = 16'h0000
- analog_test = 16'hABCD
- digital_test = 16'h0000
- amp_gain = 16'h0000
- digital_config = 16'h0001
REQ-011 Write: on a rising clk edge with reset=0 and write=1, the register selected by address SHALL load data_in; all other registers SHALL hold.
REQ-012 On a rising edge with write=0 and reset=0, all registers SHALL hold.
REQ-013 Read SHALL be combinational: data_out = register[address], zero-cycle latency from an address change, with no read enable.
REQ-014 Read-during-write SHALL return the old value before the edge and the new value after it, with no bypass of data_in.
REQ-015 All 16 bits of every register SHALL be writable and readable with no reserved or read-only bits. Both 0->1 and 1->0 transitions SHALL be supported per bit.
REQ-016 Writes SHALL be full-word only, with no byte enables.
REQ-017 Back-to-back writes to different addresses on consecutive cycles SHALL each take effect.
REQ-018 Repeated writes to the same address SHALL follow last-write-wins.
REQ-019 X/undefined address SHALL NOT corrupt any register.

Reset
REQ-020 When reset=1 at a rising edge, all eight registers SHALL take their REQ-010 values, overriding write.
REQ-021 While reset is held, data_out SHALL still reflect register[address], i.e. the reset values.
REQ-022 A reset asserted mid-sequence SHALL discard any write in that same cycle.
REQ-023 There SHALL be no asynchronous reset path.

Structure
REQ-024 Package config_reg_pkg SHALL hold:
- the register address enum (adc0_reg ... digital_config, 3-bit encoded 0-7)
- the eight reset-value constants
- DATA_W and ADDR_W defaults
REQ-025 One sub-module, cfg_reg_word, SHALL be used:
- a DATA_W-bit register with parameter RESET_VAL, inputs clk, reset, wr_en, d
- instantiated eight times with decoded write enables
REQ-026 The read mux SHALL be in the top level, selected by address.

Verification
REQ-027 Scenario: assert reset for ≥1 edge, read addresses 0..7 -> FFFF, 0000, 0000, 0000, ABCD, 0000, 0000, 0001.
REQ-028 Scenario: reset=0, write=1, data_in=16'h0110 to each address 0..7 in turn -> each reads back 0110, other registers unchanged.
REQ-029 Scenario: write 16'hFFFF to all addresses, then 16'h0000 to all addresses -> read back FFFF then 0000 per register, covering all-bit 0->1 and 1->0.
REQ-030 Scenario: walking ones: write 1<<n (n = 0..15) to each address, read after each write -> exact match, no aliasing between addresses.
REQ-031 Scenario: write=0, data_in=16'h1234 applied to all addresses -> registers keep prior values.
REQ-032 Scenario: write 16'h5A5A to amp_gain, then assert reset with write=1, data_in=16'h7777 -> amp_gain reads 0000 and analog_test reads ABCD after the edge.
